// File: rtl/mult_unit_pkg.sv
// Shared types for the MULT functional unit: function codes, per-stage packet, step width.
package mult_unit_pkg;

    typedef enum logic [2:0] {
        ALU_MUL    = 3'd0,
        ALU_MULH   = 3'd1,
        ALU_MULHSU = 3'd2,
        ALU_MULHU  = 3'd3
    } ALU_FUNC;

    // Default geometry; mult_unit parameters must match these since the packet is sized from them.
    localparam int MULT_XLEN           = 32;
    localparam int MULT_STAGES         = 4;
    localparam int MULT_TAG_W          = 6;
    localparam int MULT_BITS_PER_STAGE = (2 * MULT_XLEN) / MULT_STAGES;

    typedef struct packed {
        logic                     valid;
        logic [2*MULT_XLEN-1:0]   sum;
        logic [2*MULT_XLEN-1:0]   mcand;
        logic [2*MULT_XLEN-1:0]   mplier;
        ALU_FUNC                  func;
        logic [MULT_TAG_W-1:0]    tag;
    } mult_stage_pkt_t;

endpackage

// File: rtl/mult_unit_stage.sv
// One shift-add step of the multiplier with its pipeline register and advance handshake.
module mult_unit_stage
    import mult_unit_pkg::*;
#(
    parameter int BITS = MULT_BITS_PER_STAGE
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  mult_stage_pkt_t prev,
    input  logic            downstream_load,
    output mult_stage_pkt_t pkt,
    output logic            load
);

    localparam int PW = 2 * MULT_XLEN;

    mult_stage_pkt_t pkt_r;
    mult_stage_pkt_t next_s;
    logic [PW-1:0]   digit_s;

    // An empty or emptying stage can always take the upstream packet, so bubbles collapse.
    always_comb begin
        load = !pkt_r.valid || downstream_load;
    end

    // Retire BITS multiplier bits into the running sum.
    always_comb begin
        next_s        = prev;
        digit_s       = {{(PW-BITS){1'b0}}, prev.mplier[BITS-1:0]};
        next_s.sum    = prev.sum + (prev.mcand * digit_s);
        next_s.mcand  = prev.mcand << BITS;
        next_s.mplier = prev.mplier >> BITS;
    end

    // Stage register; flush only kills valid, data is don't-care once invalid.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pkt_r <= '0;
        end else if (flush) begin
            pkt_r.valid <= 1'b0;
        end else if (load) begin
            pkt_r <= next_s;
        end else begin
            pkt_r <= pkt_r;
        end
    end

    assign pkt = pkt_r;

endmodule

// File: rtl/mult_unit.sv
// Tagged, pipelined RV32M multiply unit with valid/ready backpressure and flush.
module mult_unit
    import mult_unit_pkg::*;
#(
    parameter int XLEN   = MULT_XLEN,
    parameter int STAGES = MULT_STAGES,
    parameter int TAG_W  = MULT_TAG_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  ALU_FUNC          in_func,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    mult_stage_pkt_t   entry_s;
    mult_stage_pkt_t   last_s;
    logic [STAGES-1:0] valid_s;
    logic              unused_bits_s;

    // Extend operands to 2*XLEN according to signedness of the function.
    always_comb begin
        entry_s       = '0;
        entry_s.valid = in_valid;
        entry_s.func  = in_func;
        entry_s.tag   = in_tag;
        case (in_func)
            ALU_MULHSU: begin
                entry_s.mcand  = {{XLEN{in_a[XLEN-1]}}, in_a};
                entry_s.mplier = {{XLEN{1'b0}}, in_b};
            end
            ALU_MULHU: begin
                entry_s.mcand  = {{XLEN{1'b0}}, in_a};
                entry_s.mplier = {{XLEN{1'b0}}, in_b};
            end
            default: begin
                entry_s.mcand  = {{XLEN{in_a[XLEN-1]}}, in_a};
                entry_s.mplier = {{XLEN{in_b[XLEN-1]}}, in_b};
            end
        endcase
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        mult_stage_pkt_t prev_s;
        mult_stage_pkt_t pkt_s;
        logic            load_s;
        logic            downstream_load_s;

        if (k == 0) begin : g_head
            assign prev_s = entry_s;
        end else begin : g_body
            assign prev_s = g_stage[k-1].pkt_s;
        end

        if (k == STAGES - 1) begin : g_tail
            assign downstream_load_s = out_ready;
        end else begin : g_link
            assign downstream_load_s = g_stage[k+1].load_s;
        end

        mult_unit_stage u_stage (
            .clock           (clock),
            .reset           (reset),
            .flush           (flush),
            .prev            (prev_s),
            .downstream_load (downstream_load_s),
            .pkt             (pkt_s),
            .load            (load_s)
        );

        assign valid_s[k] = pkt_s.valid;
    end

    assign last_s        = g_stage[STAGES-1].pkt_s;
    // After the final step the shifter state is exhausted and has no consumer.
    assign unused_bits_s = ^{last_s.mcand, last_s.mplier};

    // Output side: select the product half straight off the last stage register.
    always_comb begin
        in_ready  = g_stage[0].load_s && !flush;
        out_valid = last_s.valid;
        out_tag   = last_s.tag;
        busy      = |valid_s;
        case (last_s.func)
            ALU_MULH, ALU_MULHSU, ALU_MULHU: out_result = last_s.sum[2*XLEN-1:XLEN];
            default:                         out_result = last_s.sum[XLEN-1:0];
        endcase
    end

endmodule
